ram_prog_loader: RTL and testbench
==================================

Name: ram_prog_loader

Overview:
Sequencer that loads a program image into the 16-byte RAM from a byte stream, then releases the CPU to run it. It sits between an external byte source (host or UIO pins) and the RAM's programming port. While loading it drives prog_mode, RAM address, write data and write enable, and holds the CPU in reset. It replaces manual address/data toggling of programming mode.

Parameters:
ADDR_W, 4, RAM address width.
DATA_W, 8, RAM and stream byte width.
N_WORDS, 16, bytes per image; legal range 1..2**ADDR_W.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
load_start  input  1  pulse; starts a load from IDLE, DONE or ERROR.
abort  input  1  level; aborts an in-progress load.
byte_valid  input  1  stream byte valid.
byte_data  input  DATA_W  stream byte.
byte_ready  output  1  loader accepts a byte this cycle.
ram_addr  output  ADDR_W  RAM programming address.
ram_wdata  output  DATA_W  RAM write data.
ram_we  output  1  RAM write strobe, one cycle per byte.
prog_mode  output  1  high while the RAM is owned by the loader.
cpu_hold  output  1  holds CPU control logic and registers in reset.
words_loaded  output  ADDR_W+1  count of bytes written this load.
done  output  1  sticky; image loaded and CPU released.
error  output  1  sticky; load aborted or checksum failed.

Behaviour:
- All outputs are registered. On rst (async) every output is 0, state is IDLE, and the checksum accumulator is 0.
- Handshake: a transfer occurs on a rising edge with byte_valid && byte_ready. The source holds byte_data stable while byte_valid && !byte_ready. byte_valid may rise before byte_ready.
- States: IDLE, LOAD, WRITE, CHK (feature only), FINISH, DONE, ERROR.
- IDLE: all outputs 0. load_start -> LOAD. On entry: prog_mode=1, cpu_hold=1, ram_addr=0, words_loaded=0, done=0, error=0, checksum=0.
- LOAD: byte_ready=1. On transfer, ram_wdata<=byte_data, checksum+=byte_data (mod 2**DATA_W), and the state goes to WRITE. byte_ready is 0 in the WRITE cycle.
- WRITE: ram_we=1 for exactly one cycle, with ram_addr and ram_wdata stable. words_loaded increments at the end of the cycle.
  - If ram_addr==N_WORDS-1: go to CHK (feature on) or FINISH (feature off). ram_addr holds.
  - Otherwise ram_addr+1 and back to LOAD.
  - Throughput is at most 1 byte per 2 clocks. ram_addr never wraps within a load.
- FINISH: exactly one cycle with prog_mode=0 and cpu_hold=1, so the CPU leaves reset after the RAM is released. Then DONE.
- DONE: cpu_hold=0, done=1, byte_ready=0. load_start -> LOAD (reload; CPU re-held next cycle).
- ERROR: prog_mode=0, cpu_hold=1 (a partial image never runs), error=1, ram_we=0. Only load_start leaves it (-> LOAD).
- abort high in LOAD, WRITE or CHK -> ERROR next cycle; any pending transfer is dropped. If abort and a transfer coincide, abort wins and the byte is not written. abort is ignored in IDLE, FINISH, DONE and ERROR.
- load_start is ignored in LOAD, WRITE, CHK and FINISH.
- byte_valid outside LOAD/CHK is not consumed (byte_ready=0).
- rst mid-load: immediate return to reset values. The RAM contents written so far are untouched.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined: after the last WRITE the FSM enters CHK with byte_ready=1 and accepts one extra byte.
  - If (checksum + byte) mod 256 == 0, go to FINISH.
  - Otherwise go to ERROR.
  - The checksum byte is never written to RAM.
- Not defined: there is no CHK state and no accumulator logic, and WRITE of the last byte goes directly to FINISH.

Test Plan:
- Reset mid-LOAD (after 5 bytes) -> all outputs 0 within the same cycle (async), IDLE. A following load_start restarts at ram_addr=0.
- load_start, then 16 bytes 0x00..0x0F with byte_valid held high:
  - 16 one-cycle ram_we pulses, at addr i with data i, spaced 2 clocks.
  - Then 1 cycle of prog_mode=0/cpu_hold=1, then done=1, cpu_hold=0, words_loaded=16.
- Backpressure/gaps: byte_valid toggles randomly over a 16-byte image -> the same RAM writes in order, with no duplicated or dropped bytes and ram_we only in WRITE.
- abort asserted coincident with the 3rd transfer -> no write at addr 2, error=1, cpu_hold=1, prog_mode=0, words_loaded=2. Then load_start -> clean reload to done.
- N_WORDS=4, LOADER_CHECKSUM_EN defined:
  - Bytes 0x10,0x20,0x30,0x40, checksum 0x60 -> done=1.
  - Checksum 0x61 -> error=1, cpu_hold=1.
  - In both cases there are 4 writes and the checksum byte is never written.
- From DONE, load_start -> cpu_hold=1 and prog_mode=1 next cycle, done=0, ram_addr=0.

Source files
------------

// File: rtl/ram_prog_loader.sv
// Byte-stream program loader for the CPU's RAM: owns the RAM programming port and holds the CPU in reset while an image streams in.
// Optional trailing checksum byte verification is enabled with `define LOADER_CHECKSUM_EN.
module ram_prog_loader #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int N_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              prog_mode,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   words_loaded,
  output logic              done,
  output logic              error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WRITE  = 3'd2,
    S_CHK    = 3'd3,
    S_FINISH = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WRITE  = 3'd2,
    S_FINISH = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  state_e              state_q, state_d;
  logic                byte_ready_q, byte_ready_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                ram_we_q, ram_we_d;
  logic                prog_mode_q, prog_mode_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                xfer_s;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   checksum_q, checksum_d;
`endif

  assign xfer_s = byte_valid && byte_ready_q;

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d        = state_q;
    byte_ready_d   = byte_ready_q;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    ram_we_d       = 1'b0;
    prog_mode_d    = prog_mode_q;
    cpu_hold_d     = cpu_hold_q;
    words_loaded_d = words_loaded_q;
    done_d         = done_q;
    error_d        = error_q;
`ifdef LOADER_CHECKSUM_EN
    checksum_d     = checksum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_start) begin
          state_d        = S_LOAD;
          byte_ready_d   = 1'b1;
          ram_addr_d     = {ADDR_W{1'b0}};
          prog_mode_d    = 1'b1;
          cpu_hold_d     = 1'b1;
          words_loaded_d = {(ADDR_W+1){1'b0}};
          done_d         = 1'b0;
          error_d        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          checksum_d     = {DATA_W{1'b0}};
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d      = S_ERROR;
          byte_ready_d = 1'b0;
          prog_mode_d  = 1'b0;
          cpu_hold_d   = 1'b1;
          error_d      = 1'b1;
        end else if (xfer_s) begin
          state_d      = S_WRITE;
          byte_ready_d = 1'b0;
          ram_wdata_d  = byte_data;
          ram_we_d     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = checksum_q + byte_data;
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        // The strobe for this byte is already on the port, so it counts even if abort arrives now.
        words_loaded_d = words_loaded_q + {{ADDR_W{1'b0}}, 1'b1};
        if (abort) begin
          state_d      = S_ERROR;
          byte_ready_d = 1'b0;
          prog_mode_d  = 1'b0;
          cpu_hold_d   = 1'b1;
          error_d      = 1'b1;
        end else if (ram_addr_q == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
          state_d      = S_CHK;
          byte_ready_d = 1'b1;
`else
          state_d      = S_FINISH;
          byte_ready_d = 1'b0;
          prog_mode_d  = 1'b0;
          cpu_hold_d   = 1'b1;
`endif
        end else begin
          state_d      = S_LOAD;
          byte_ready_d = 1'b1;
          ram_addr_d   = ram_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (abort || (xfer_s && ((checksum_q + byte_data) != {DATA_W{1'b0}}))) begin
          state_d      = S_ERROR;
          byte_ready_d = 1'b0;
          prog_mode_d  = 1'b0;
          cpu_hold_d   = 1'b1;
          error_d      = 1'b1;
        end else if (xfer_s) begin
          state_d      = S_FINISH;
          byte_ready_d = 1'b0;
          prog_mode_d  = 1'b0;
          cpu_hold_d   = 1'b1;
        end else begin
          state_d = S_CHK;
        end
      end
`endif
      S_FINISH: begin
        // RAM was released a cycle earlier, so the CPU leaves reset onto a stable image.
        state_d     = S_DONE;
        cpu_hold_d  = 1'b0;
        done_d      = 1'b1;
      end
      default: begin
        state_d        = S_IDLE;
        byte_ready_d   = 1'b0;
        ram_addr_d     = {ADDR_W{1'b0}};
        ram_wdata_d    = {DATA_W{1'b0}};
        prog_mode_d    = 1'b0;
        cpu_hold_d     = 1'b0;
        words_loaded_d = {(ADDR_W+1){1'b0}};
        done_d         = 1'b0;
        error_d        = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      byte_ready_q   <= 1'b0;
      ram_addr_q     <= {ADDR_W{1'b0}};
      ram_wdata_q    <= {DATA_W{1'b0}};
      ram_we_q       <= 1'b0;
      prog_mode_q    <= 1'b0;
      cpu_hold_q     <= 1'b0;
      words_loaded_q <= {(ADDR_W+1){1'b0}};
      done_q         <= 1'b0;
      error_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q     <= {DATA_W{1'b0}};
`endif
    end else begin
      state_q        <= state_d;
      byte_ready_q   <= byte_ready_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      ram_we_q       <= ram_we_d;
      prog_mode_q    <= prog_mode_d;
      cpu_hold_q     <= cpu_hold_d;
      words_loaded_q <= words_loaded_d;
      done_q         <= done_d;
      error_q        <= error_d;
`ifdef LOADER_CHECKSUM_EN
      checksum_q     <= checksum_d;
`endif
    end
  end

  assign byte_ready   = byte_ready_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign ram_we       = ram_we_q;
  assign prog_mode    = prog_mode_q;
  assign cpu_hold     = cpu_hold_q;
  assign words_loaded = words_loaded_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_ram_prog_loader.sv
// Directed bench for ram_prog_loader (16-byte image); checksum scenarios run when LOADER_CHECKSUM_EN is defined.
module tb_ram_prog_loader;
  logic       clk = 1'b0;
  logic       rst, load_start, abort, byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready, ram_we, prog_mode, cpu_hold, done, error;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [4:0] words_loaded;

  int n_cmp = 0;
  int n_bad = 0;

  ram_prog_loader #(.ADDR_W(4), .DATA_W(8), .N_WORDS(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .prog_mode(prog_mode), .cpu_hold(cpu_hold), .words_loaded(words_loaded),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write monitor: logs every RAM write strobe and flags strobes that are not single, ready-free cycles.
  int         cyc = 0;
  int         we_bad = 0;
  logic       prev_we = 1'b0;
  logic [3:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_we <= ram_we;
    if (ram_we === 1'b1) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_wdata);
      wr_cyc.push_back(cyc);
      if (prev_we === 1'b1 || byte_ready === 1'b1) we_bad <= we_bad + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit gaps);
    int n;
    bit acc;
    acc = 1'b0;
    if (gaps) begin
      n = $urandom_range(0, 2);
      if (n > 0) begin
        byte_valid = 1'b0;
        repeat (n) tick();
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = byte_ready;
      tick();
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout byte=%h accepted=0 required=1", b);
    end
  endtask

  task automatic load_image(input logic [7:0] d0, input logic [7:0] step, input bit gaps,
                            output logic [7:0] sum);
    sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      push_byte(d0 + 8'(i) * step, gaps);
      sum = sum + d0 + 8'(i) * step;
    end
    byte_valid = 1'b0;
  endtask

  // Drives the tail of a good load (checksum byte when enabled) and checks FINISH then DONE.
  task automatic finish_seq(input logic [7:0] sum, input string tag);
`ifdef LOADER_CHECKSUM_EN
    push_byte(8'h00 - sum, 1'b0);
    byte_valid = 1'b0;
`else
    tick();
`endif
    n_cmp++;
    if ({prog_mode, cpu_hold, done, error} !== 4'b0100) begin
      n_bad++;
      $display("FAIL %s_finish got=%b want=0100 sum=%h", tag, {prog_mode, cpu_hold, done, error}, sum);
    end
    tick();
    n_cmp++;
    if ({prog_mode, cpu_hold, done, error, byte_ready, words_loaded} !== {5'b00100, 5'd16}) begin
      n_bad++;
      $display("FAIL %s_done got=%b/%0d want=00100/16", tag,
               {prog_mode, cpu_hold, done, error, byte_ready}, words_loaded);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({byte_ready, ram_we, prog_mode, cpu_hold, done, error, ram_addr, ram_wdata, words_loaded} !== 23'd0) begin
      n_bad++; $display("FAIL reset_values got=%h want=0", {byte_ready, ram_we, prog_mode, cpu_hold, done, error});
    end
    rst = 1'b0;
    tick();
    pulse_start();
    n_cmp++;
    if ({prog_mode, cpu_hold, byte_ready, ram_addr} !== {3'b111, 4'd0}) begin
      n_bad++; $display("FAIL start_from_idle got=%b want=1110000", {prog_mode, cpu_hold, byte_ready, ram_addr});
    end
    for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i), 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({byte_ready, ram_we, prog_mode, cpu_hold, done, error, ram_addr, ram_wdata, words_loaded} !== 23'd0) begin
      n_bad++; $display("FAIL async_reset_midload got=%b addr=%0d wl=%0d want=0",
                        {byte_ready, ram_we, prog_mode, cpu_hold}, ram_addr, words_loaded);
    end
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    n_cmp++;
    if ({prog_mode, cpu_hold, byte_ready, ram_addr, words_loaded} !== {3'b111, 4'd0, 5'd0}) begin
      n_bad++; $display("FAIL restart_after_reset got addr=%0d wl=%0d pm=%b want addr=0 wl=0 pm=1",
                        ram_addr, words_loaded, prog_mode);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_load();
    int base;
    logic [7:0] sum;
    base = wr_addr.size();
    pulse_start();
    load_image(8'h00, 8'h01, 1'b0, sum);
    finish_seq(sum, "full");
    n_cmp++;
    if (wr_addr.size() - base !== 16) begin
      n_bad++; $display("FAIL full_write_count got=%0d want=16", wr_addr.size() - base);
    end
    for (int i = 0; i < 16 && base + i < wr_addr.size(); i++) begin
      n_cmp++;
      if ({wr_addr[base+i], wr_data[base+i]} !== {4'(i), 8'(i)}) begin
        n_bad++; $display("FAIL full_write_%0d got=%0d:%h want=%0d:%h", i, wr_addr[base+i], wr_data[base+i], i, i);
      end
      if (i > 0) begin
        n_cmp++;
        if (wr_cyc[base+i] - wr_cyc[base+i-1] !== 2) begin
          n_bad++; $display("FAIL full_spacing_%0d got=%0d want=2", i, wr_cyc[base+i] - wr_cyc[base+i-1]);
        end
      end
    end
    n_cmp++;
    if (we_bad !== 0) begin
      n_bad++; $display("FAIL we_pulse_shape got=%0d want=0", we_bad);
    end
  endtask

  task automatic test_from_done();
    pulse_start();
    n_cmp++;
    if ({prog_mode, cpu_hold, done, error, byte_ready, ram_addr, words_loaded} !== {5'b11001, 4'd0, 5'd0}) begin
      n_bad++; $display("FAIL reload_from_done got=%b addr=%0d wl=%0d want=11001 addr=0 wl=0",
                        {prog_mode, cpu_hold, done, error, byte_ready}, ram_addr, words_loaded);
    end
  endtask

  task automatic test_backpressure();
    int base;
    logic [7:0] sum;
    logic [7:0] exp_d;
    base = wr_addr.size();
    load_image(8'h37, 8'h0B, 1'b1, sum);
    finish_seq(sum, "gaps");
    n_cmp++;
    if (wr_addr.size() - base !== 16) begin
      n_bad++; $display("FAIL gaps_write_count got=%0d want=16", wr_addr.size() - base);
    end
    for (int i = 0; i < 16 && base + i < wr_addr.size(); i++) begin
      exp_d = 8'h37 + 8'(i) * 8'h0B;
      n_cmp++;
      if ({wr_addr[base+i], wr_data[base+i]} !== {4'(i), exp_d}) begin
        n_bad++; $display("FAIL gaps_write_%0d got=%0d:%h want=%0d:%h", i, wr_addr[base+i], wr_data[base+i], i, exp_d);
      end
    end
    n_cmp++;
    if (we_bad !== 0) begin
      n_bad++; $display("FAIL gaps_we_pulse_shape got=%0d want=0", we_bad);
    end
  endtask

  task automatic test_abort();
    int base;
    logic [7:0] sum;
    pulse_start();
    base = wr_addr.size();
    push_byte(8'hC0, 1'b0);
    push_byte(8'hC1, 1'b0);
    byte_valid = 1'b0;
    tick();
    byte_valid = 1'b1;
    byte_data  = 8'hC2;
    abort      = 1'b1;
    tick();
    abort      = 1'b0;
    byte_valid = 1'b0;
    n_cmp++;
    if ({prog_mode, cpu_hold, done, error, byte_ready, words_loaded} !== {5'b01010, 5'd2}) begin
      n_bad++; $display("FAIL abort_state got=%b wl=%0d want=01010 wl=2",
                        {prog_mode, cpu_hold, done, error, byte_ready}, words_loaded);
    end
    repeat (3) tick();
    n_cmp++;
    if ({cpu_hold, error, prog_mode} !== 3'b110) begin
      n_bad++; $display("FAIL abort_sticky got=%b want=110", {cpu_hold, error, prog_mode});
    end
    n_cmp++;
    if (wr_addr.size() - base !== 2) begin
      n_bad++; $display("FAIL abort_write_count got=%0d want=2", wr_addr.size() - base);
    end
    pulse_start();
    n_cmp++;
    if ({prog_mode, cpu_hold, done, error, byte_ready, ram_addr} !== {5'b11001, 4'd0}) begin
      n_bad++; $display("FAIL reload_from_error got=%b addr=%0d want=11001 addr=0",
                        {prog_mode, cpu_hold, done, error, byte_ready}, ram_addr);
    end
    base = wr_addr.size();
    load_image(8'h80, 8'h03, 1'b0, sum);
    finish_seq(sum, "reload");
    n_cmp++;
    if (wr_addr.size() - base !== 16) begin
      n_bad++; $display("FAIL reload_write_count got=%0d want=16", wr_addr.size() - base);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    int base;
    logic [7:0] sum;
    pulse_start();
    base = wr_addr.size();
    load_image(8'h10, 8'h10, 1'b0, sum);
    push_byte(8'h01 - sum, 1'b0);
    byte_valid = 1'b0;
    n_cmp++;
    if ({prog_mode, cpu_hold, done, error, byte_ready, words_loaded} !== {5'b01010, 5'd16}) begin
      n_bad++; $display("FAIL bad_checksum got=%b wl=%0d want=01010 wl=16",
                        {prog_mode, cpu_hold, done, error, byte_ready}, words_loaded);
    end
    repeat (2) tick();
    n_cmp++;
    if (wr_addr.size() - base !== 16) begin
      n_bad++; $display("FAIL chk_write_count got=%0d want=16", wr_addr.size() - base);
    end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    abort      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) tick();
    test_reset();
    test_full_load();
    test_from_done();
    test_backpressure();
    test_abort();
`ifdef LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
